// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with status display mux.
// Optional build macro SIGNED_EN: two's complement input, magnitude + sign.
module bin_to_bcd_seq #(
  parameter int DATA_W = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     data_bin,
  input  logic                  not_out,
  input  logic                  flag_w,
  input  logic                  hlt,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int BW = 4 * DIGITS;
  localparam logic [11:0] HALT_PAT = 12'hCDE;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] sreg;
  logic [BW-1:0]     acc;
  logic [BW-1:0]     result;
  logic [CW-1:0]     cnt;
  logic              ovf_acc;
  logic              sign_pend;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     acc_nx;
  logic              carry;
  logic [DATA_W-1:0] sreg_nx;
  logic [DATA_W-1:0] mag;
  logic              sgn_in;
  logic              last;
  logic [BW-1:0]     res_nx;
  logic [BW-1:0]     disp_nx;

`ifdef SIGNED_EN
  assign sgn_in = data_bin[DATA_W-1];
  assign mag    = sgn_in ? (~data_bin) + DATA_W'(1)
                         : data_bin;
`else
  assign sgn_in = 1'b0;
  assign mag    = data_bin;
`endif

  // Add 3 to every digit above 4 before the shift
  always_comb begin
    adj = acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc[4*k +: 4] > 4'd4)
        adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
    end
  end

  assign {carry, acc_nx} = {adj, sreg[DATA_W-1]};
  assign sreg_nx = sreg << 1;
  assign last    = (state == SHIFT) && (cnt == '0);

  // Result as it will be after this edge, so display tracks done
  always_comb begin
    res_nx = result;
    if (last)
      res_nx = acc_nx;
  end

  // Status code priority mux feeding the digit register
  always_comb begin
    disp_nx = {DIGITS{4'hA}};
    priority case (1'b1)
      hlt: begin
        for (int k = 0; k < 3 && k < DIGITS; k++)
          disp_nx[4*k +: 4] = HALT_PAT[4*k +: 4];
      end
      flag_w:  disp_nx = {DIGITS{4'hB}};
      not_out: disp_nx = {DIGITS{4'hA}};
      default: disp_nx = res_nx;
    endcase
  end

  // Conversion FSM with registered handshake outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      sign      <= 1'b0;
      sign_pend <= 1'b0;
      result    <= '0;
      sreg      <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf_acc   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            sreg      <= mag;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            cnt       <= CW'(DATA_W - 1);
            sign_pend <= sgn_in;
            busy      <= 1'b1;
            state     <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sreg    <= sreg_nx;
          acc     <= acc_nx;
          ovf_acc <= ovf_acc | carry;
          cnt     <= cnt - CW'(1);
          if (cnt == '0) begin
            result <= acc_nx;
            ovf    <= ovf_acc | carry;
            sign   <= sign_pend;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered digit bus
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      bcd_out <= {DIGITS{4'hA}};
    else
      bcd_out <= disp_nx;
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (10-digit and 8-digit instances).
// Random values are checked against a decimal arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] data_bin;
  logic        not_out;
  logic        flag_w;
  logic        hlt;

  logic        busy, done, ovf, sign;
  logic [39:0] bcd_out;
  logic        busy8, done8, ovf8, sign8;
  logic [31:0] bcd8;

  int checks = 0;
  int errors = 0;

  localparam logic [39:0] ALL_A10 = {10{4'hA}};
  localparam logic [31:0] ALL_A8  = {8{4'hA}};

  always #5 clock = ~clock;

  bin_to_bcd_seq #(.DATA_W(32), .DIGITS(10)) dut (
    .clock(clock), .reset(reset), .start(start),
    .data_bin(data_bin), .not_out(not_out),
    .flag_w(flag_w), .hlt(hlt), .busy(busy),
    .done(done), .ovf(ovf), .sign(sign),
    .bcd_out(bcd_out)
  );

  bin_to_bcd_seq #(.DATA_W(32), .DIGITS(8)) dut8 (
    .clock(clock), .reset(reset), .start(start),
    .data_bin(data_bin), .not_out(not_out),
    .flag_w(flag_w), .hlt(hlt), .busy(busy8),
    .done(done8), .ovf(ovf8), .sign(sign8),
    .bcd_out(bcd8)
  );

  function automatic longint unsigned m_mag(input logic [31:0] d);
    longint unsigned v;
    v = {32'd0, d};
`ifdef SIGNED_EN
    if (d[31]) v = 64'h1_0000_0000 - v;
`endif
    return v;
  endfunction

  function automatic logic m_sign(input logic [31:0] d);
`ifdef SIGNED_EN
    return d[31];
`else
    return 1'b0 & d[0];
`endif
  endfunction

  function automatic logic [39:0] m_bcd(input longint unsigned v,
                                        input int nd);
    logic [39:0] r;
    longint unsigned t;
    r = '0;
    t = v;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic m_ovf(input longint unsigned v, input int nd);
    longint unsigned p;
    p = 1;
    for (int k = 0; k < nd; k++) p = p * 10;
    return v >= p;
  endfunction

  logic        r_to, r_dn8, r_dnext;
  int          r_bc;
  logic [39:0] r_b10;
  logic [31:0] r_b8;
  logic        r_o10, r_s10, r_o8, r_s8;

  task automatic run_conv(input logic [31:0] d);
    int n;
    @(negedge clock);
    data_bin = d;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    data_bin = $urandom;
    r_bc = 0;
    n = 0;
    while (!done && n < 200) begin
      if (busy) r_bc++;
      @(negedge clock);
      n++;
    end
    r_to  = !done;
    r_dn8 = done8;
    r_b10 = bcd_out;
    r_o10 = ovf;
    r_s10 = sign;
    r_b8  = bcd8;
    r_o8  = ovf8;
    r_s8  = sign8;
    @(negedge clock);
    r_dnext = done;
  endtask

  task automatic check_conv(input string nm, input logic [31:0] d);
    longint unsigned v;
    v = m_mag(d);
    checks++;
    if (r_to) begin
      errors++;
      $display("FAIL %s timeout: done never seen for %h", nm, d);
    end
    checks++;
    if (r_b10 !== m_bcd(v, 10)) begin
      errors++;
      $display("FAIL %s bcd10 got %h exp %h", nm, r_b10, m_bcd(v, 10));
    end
    checks++;
    if (r_o10 !== m_ovf(v, 10) || r_s10 !== m_sign(d)) begin
      errors++;
      $display("FAIL %s ovf/sign10 got %b%b exp %b%b", nm,
               r_o10, r_s10, m_ovf(v, 10), m_sign(d));
    end
    checks++;
    if (r_b8 !== 32'(m_bcd(v, 8)) || r_dn8 !== 1'b1) begin
      errors++;
      $display("FAIL %s bcd8 got %h done8 %b exp %h", nm,
               r_b8, r_dn8, 32'(m_bcd(v, 8)));
    end
    checks++;
    if (r_o8 !== m_ovf(v, 8) || r_s8 !== m_sign(d)) begin
      errors++;
      $display("FAIL %s ovf/sign8 got %b%b exp %b%b", nm,
               r_o8, r_s8, m_ovf(v, 8), m_sign(d));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done) && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    data_bin = '0;
    not_out = 1'b0;
    flag_w = 1'b0;
    hlt = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, done, ovf, sign} !== 4'b0 || bcd_out !== ALL_A10) begin
      errors++;
      $display("FAIL reset got b%b d%b o%b s%b bcd %h exp 0000 %h",
               busy, done, ovf, sign, bcd_out, ALL_A10);
    end
    checks++;
    if ({busy8, done8, ovf8} !== 3'b0 || bcd8 !== ALL_A8) begin
      errors++;
      $display("FAIL reset8 got %b bcd %h exp 000 %h",
               {busy8, done8, ovf8}, bcd8, ALL_A8);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bcd_out !== 40'd0) begin
      errors++;
      $display("FAIL reset_result got %h exp 0", bcd_out);
    end
  endtask

  task automatic test_max();
    run_conv(32'hFFFF_FFFF);
    check_conv("max", 32'hFFFF_FFFF);
    checks++;
    if (r_bc != 32) begin
      errors++;
      $display("FAIL max_busy_cycles got %0d exp 32", r_bc);
    end
    checks++;
    if (r_dnext !== 1'b0) begin
      errors++;
      $display("FAIL max_done_width got %b exp 0", r_dnext);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] fixed [4];
    fixed[0] = 32'd12345;
    fixed[1] = 32'd123456789;
    fixed[2] = 32'd5;
    fixed[3] = 32'd0;
    for (int i = 0; i < 24; i++) begin
      if (i < 4) d = fixed[i];
      else if (i % 3 == 0) d = $urandom_range(0, 99999999);
      else d = $urandom;
      run_conv(d);
      check_conv("random", d);
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    longint unsigned v;
    v = m_mag(32'd12345);
    @(negedge clock);
    data_bin = 32'd12345;
    start = 1'b1;
    for (int c = 0; c < 140; c++) begin
      @(negedge clock);
      if (done) begin
        q.push_back(c);
        checks++;
        if (bcd_out !== m_bcd(v, 10)) begin
          errors++;
          $display("FAIL b2b_value got %h exp %h", bcd_out, m_bcd(v, 10));
        end
      end
    end
    start = 1'b0;
    checks++;
    if (q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 4", q.size());
    end
    for (int i = 1; i < q.size(); i++) begin
      checks++;
      if (q[i] - q[i-1] != 33) begin
        errors++;
        $display("FAIL b2b_period got %0d exp 33", q[i] - q[i-1]);
      end
    end
    wait_idle();
  endtask

  task automatic test_status();
    logic [31:0] d;
    run_conv(32'd42);
    check_conv("status_base", 32'd42);
    @(negedge clock);
    not_out = 1'b1;
    @(negedge clock);
    checks++;
    if (bcd_out !== ALL_A10) begin
      errors++;
      $display("FAIL not_out got %h exp %h", bcd_out, ALL_A10);
    end
    flag_w = 1'b1;
    @(negedge clock);
    checks++;
    if (bcd_out !== {10{4'hB}}) begin
      errors++;
      $display("FAIL flag_w got %h exp %h", bcd_out, {10{4'hB}});
    end
    hlt = 1'b1;
    @(negedge clock);
    checks++;
    if (bcd_out !== 40'hAAAAAAACDE || bcd8 !== 32'hAAAAACDE) begin
      errors++;
      $display("FAIL hlt got %h/%h exp AAAAAAACDE/AAAAACDE",
               bcd_out, bcd8);
    end
    hlt = 1'b0;
    flag_w = 1'b0;
    not_out = 1'b0;
    @(negedge clock);
    checks++;
    if (bcd_out !== m_bcd(64'd42, 10)) begin
      errors++;
      $display("FAIL status_release got %h exp 42", bcd_out);
    end
    d = $urandom;
    flag_w = 1'b1;
    run_conv(d);
    checks++;
    if (r_bc != 32 || r_to || r_b10 !== {10{4'hB}}) begin
      errors++;
      $display("FAIL status_during_conv busy %0d bcd %h exp 32 %h",
               r_bc, r_b10, {10{4'hB}});
    end
    flag_w = 1'b0;
    @(negedge clock);
    checks++;
    if (bcd_out !== m_bcd(m_mag(d), 10)) begin
      errors++;
      $display("FAIL status_after_conv got %h exp %h",
               bcd_out, m_bcd(m_mag(d), 10));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    @(negedge clock);
    data_bin = $urandom;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== ALL_A10) begin
      errors++;
      $display("FAIL reset_mid got b%b d%b %h exp b0 d0 %h",
               busy, done, bcd_out, ALL_A10);
    end
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins_start got busy %b exp 0", busy);
    end
    d = $urandom;
    run_conv(d);
    check_conv("after_reset", d);
    checks++;
    if (r_bc != 32) begin
      errors++;
      $display("FAIL after_reset_busy got %0d exp 32", r_bc);
    end
  endtask

  task automatic test_signed();
    run_conv(32'hFFFF_FFFF);
    check_conv("signed_m1", 32'hFFFF_FFFF);
    run_conv(32'h8000_0000);
    check_conv("signed_min", 32'h8000_0000);
    checks++;
`ifdef SIGNED_EN
    if (r_b10 !== 40'h2147483648 || r_s10 !== 1'b1 || r_o10 !== 1'b0) begin
      errors++;
      $display("FAIL signed_min_abs got %h s%b o%b exp 2147483648 s1 o0",
               r_b10, r_s10, r_o10);
    end
`else
    if (r_b10 !== 40'h2147483648 || r_s10 !== 1'b0) begin
      errors++;
      $display("FAIL unsigned_min got %h s%b exp 2147483648 s0",
               r_b10, r_s10);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_max();
    test_random();
    test_back_to_back();
    test_status();
    test_reset_mid();
    test_signed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
